music_box_recorder: RTL and testbench

Parametrised recording engine for the music box's "make recording" UI state. On a sample-rate strobe it captures samples into a small FIFO and drains them to SDRAM through the shared controller handshake. Writes are acknowledged by the controller before each next command. It supports selectable recording slots, early stop, overrun detection and a progress count, and it signals `stateComplete` back to the music box state controller.

---
 rtl/music_box_pkg.sv | 32 +++
 rtl/recorder_sample_fifo.sv | 64 ++++++
 rtl/music_box_recorder.sv | 153 +++++++++++++++
 tb/tb_music_box_recorder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_box_pkg.sv
// Shared definitions for the music box recording engine.
//   rec_state_t        recorder FSM encoding (3 bits, exported on debugString)
//   SDRAM_ADDR_W/DATA  SDRAM controller command widths
//   ST_MAKE_RECORDING  mainState value of the "make recording" UI state
//   slot_base()        clamped slot index times slot stride, 25-bit wrap
package music_box_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  localparam logic [4:0] ST_MAKE_RECORDING = 5'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RECORD = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } rec_state_t;

  // Indices past the last slot land on the last slot rather than aliasing.
  function automatic logic [SDRAM_ADDR_W-1:0] slot_base(
    input int unsigned               idx,
    input int unsigned               count,
    input logic [SDRAM_ADDR_W-1:0]   stride
  );
    int unsigned clamped;
    clamped = (idx >= count) ? count - 1 : idx;
    return SDRAM_ADDR_W'(clamped) * stride;
  endfunction

endpackage

// File: rtl/recorder_sample_fifo.sv
// Small synchronous sample FIFO for the recorder.
//   clock_50Mhz, reset_n : clock, async active-low reset
//   flush                : empties the FIFO (wins over push/pop)
//   push, din            : write request and data; ignored when full unless popping
//   pop                  : read request; ignored when empty
//   dout                 : current head (valid while !empty)
//   full, empty          : occupancy flags
module recorder_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock_50Mhz,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock_50Mhz) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/music_box_recorder.sv
// Recording engine for the music box "make recording" UI state.
// Captures strobed samples into a FIFO and writes them to SDRAM through the
// shared controller handshake, one outstanding command at a time.
//   clock_50Mhz, reset_n      : clock, async active-low reset
//   mainState                 : UI state; ACTIVE_STATE enables the block
//   sample_strobe, sample_in  : sample-rate pulse and sample
//   slot_select               : recording slot, latched on entry to ARM
//   stop_request              : ends capture early
//   stateComplete             : recording finished and fully written
//   samples_written           : acknowledged SDRAM writes
//   overrun                   : sticky, a sample was dropped on a full FIFO
//   debugString               : {state, overrun, 4'b0, samples_written}
//   sdram_*                   : controller command outputs / status inputs
//
// state  | meaning
// IDLE   | waiting for mainState == ACTIVE_STATE
// ARM    | one cycle; slot base latched, counters/FIFO cleared on entry
// RECORD | accepting strobes, writer running
// DRAIN  | capture closed, writer empties the FIFO
// DONE   | all samples written, stateComplete high
module music_box_recorder
  import music_box_pkg::*;
#(
  parameter int                      SAMPLE_W     = 8,
  parameter int                      MAX_SAMPLES  = 220500,
  parameter int                      SLOT_COUNT   = 4,
  parameter logic [SDRAM_ADDR_W-1:0] SLOT_STRIDE  = 25'h080000,
  parameter int                      FIFO_DEPTH   = 8,
  parameter logic [4:0]              ACTIVE_STATE = ST_MAKE_RECORDING,
  localparam int                     CNT_W        = $clog2(MAX_SAMPLES + 1),
  localparam int                     SLOT_W       = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset_n,
  input  logic [4:0]              mainState,
  input  logic                    sample_strobe,
  input  logic [SAMPLE_W-1:0]     sample_in,
  input  logic [SLOT_W-1:0]       slot_select,
  input  logic                    stop_request,
  output logic                    stateComplete,
  output logic [CNT_W-1:0]        samples_written,
  output logic                    overrun,
  output logic [31:0]             debugString,
  output logic [SDRAM_ADDR_W-1:0] sdram_inputAddress,
  output logic [SDRAM_DATA_W-1:0] sdram_writeData,
  output logic                    sdram_isWriting,
  output logic                    sdram_inputValid,
  input  logic                    sdram_recievedCommand,
  input  logic                    sdram_isBusy
);

  rec_state_t              state, state_nxt;
  logic [SDRAM_ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]        capture_left;

  logic                    active;
  logic                    abort;
  logic                    arm_entry;
  logic                    writer_on;
  logic                    push_req;
  logic                    push_accept;
  logic                    ack;
  logic                    issue;

  logic                    fifo_flush;
  logic [SAMPLE_W-1:0]     fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign active     = (mainState == ACTIVE_STATE);
  assign abort      = (state != IDLE) && !active;
  assign arm_entry  = (state == IDLE) && active;
  assign writer_on  = active && ((state == RECORD) || (state == DRAIN));
  assign push_req   = active && (state == RECORD) && sample_strobe;
  assign ack        = writer_on && sdram_inputValid && sdram_recievedCommand;
  // The head pops on the accepting edge, so a full FIFO can still take a sample.
  assign push_accept = push_req && (!fifo_full || ack);
  assign issue      = writer_on && !sdram_inputValid && !fifo_empty && !sdram_isBusy;
  assign fifo_flush = arm_entry || abort;

  recorder_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .flush       (fifo_flush),
    .push        (push_accept),
    .pop         (ack),
    .din         (sample_in),
    .dout        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (active) state_nxt = ARM;
        ARM:     state_nxt = RECORD;
        RECORD:  if (stop_request || (push_accept && capture_left == CNT_W'(1)))
                   state_nxt = DRAIN;
        DRAIN:   if (fifo_empty && !sdram_inputValid) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      base_addr          <= '0;
      capture_left       <= '0;
      samples_written    <= '0;
      overrun            <= 1'b0;
      sdram_inputValid   <= 1'b0;
      sdram_isWriting    <= 1'b0;
      sdram_inputAddress <= '0;
      sdram_writeData    <= '0;
    end else begin
      state <= state_nxt;

      if (arm_entry) begin
        base_addr       <= slot_base(32'(slot_select), SLOT_COUNT, SLOT_STRIDE);
        capture_left    <= CNT_W'(MAX_SAMPLES);
        samples_written <= '0;
        overrun         <= 1'b0;
      end else begin
        if (push_accept)             capture_left    <= capture_left - CNT_W'(1);
        if (push_req && !push_accept) overrun        <= 1'b1;
        if (ack)                     samples_written <= samples_written + CNT_W'(1);
      end

      if (abort || ack) begin
        sdram_inputValid <= 1'b0;
        sdram_isWriting  <= 1'b0;
      end else if (issue) begin
        sdram_inputValid   <= 1'b1;
        sdram_isWriting    <= 1'b1;
        sdram_inputAddress <= base_addr + SDRAM_ADDR_W'(samples_written);
        sdram_writeData    <= SDRAM_DATA_W'(fifo_head);
      end
    end
  end

  assign stateComplete = (state == DONE);
  assign debugString   = {3'(state), overrun, 4'b0, 24'(samples_written)};

endmodule

// File: tb/tb_music_box_recorder.sv
module tb_music_box_recorder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  mainState;
  logic        sample_strobe;
  logic [7:0]  sample_in;
  logic [1:0]  slot_select;
  logic        stop_request;
  logic        stateComplete;
  logic [3:0]  samples_written;
  logic        overrun;
  logic [31:0] debugString;
  logic [24:0] sdram_inputAddress;
  logic [15:0] sdram_writeData;
  logic        sdram_isWriting;
  logic        sdram_inputValid;
  logic        sdram_recievedCommand;
  logic        sdram_isBusy;

  int total = 0;
  int bad   = 0;
  int ack_delay = 1;
  int vcnt = 0;
  logic [24:0] log_addr[$];
  logic [15:0] log_data[$];

  always #5 clk = ~clk;

  music_box_recorder #(
    .SAMPLE_W     (8),
    .MAX_SAMPLES  (8),
    .SLOT_COUNT   (4),
    .SLOT_STRIDE  (25'h100),
    .FIFO_DEPTH   (4),
    .ACTIVE_STATE (5'd4)
  ) dut (
    .clock_50Mhz           (clk),
    .reset_n               (reset_n),
    .mainState             (mainState),
    .sample_strobe         (sample_strobe),
    .sample_in             (sample_in),
    .slot_select           (slot_select),
    .stop_request          (stop_request),
    .stateComplete         (stateComplete),
    .samples_written       (samples_written),
    .overrun               (overrun),
    .debugString           (debugString),
    .sdram_inputAddress    (sdram_inputAddress),
    .sdram_writeData       (sdram_writeData),
    .sdram_isWriting       (sdram_isWriting),
    .sdram_inputValid      (sdram_inputValid),
    .sdram_recievedCommand (sdram_recievedCommand),
    .sdram_isBusy          (sdram_isBusy)
  );

  // Controller model: acknowledges a command once it has been valid for ack_delay cycles.
  always @(posedge clk) begin
    #1;
    if (sdram_inputValid && !sdram_recievedCommand) begin
      vcnt++;
      if (vcnt >= ack_delay) sdram_recievedCommand = 1'b1;
    end else begin
      sdram_recievedCommand = 1'b0;
      vcnt = 0;
    end
  end

  // Commands that the controller is accepting at the coming edge.
  always @(negedge clk) begin
    if (reset_n && sdram_inputValid && sdram_recievedCommand) begin
      log_addr.push_back(sdram_inputAddress);
      log_data.push_back(sdram_writeData);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (debugString[31:29] !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(debugString[31:29]), 32'(st));
  endtask

  task automatic strobe(input logic [7:0] val, input int gap);
    sample_in = val;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int k = 1; k < gap; k++) tick();
  endtask

  task automatic stop_pulse();
    stop_request = 1'b1;
    tick();
    stop_request = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input logic [24:0] base,
                              input logic [15:0] first);
    chk({tag, "_count"}, 32'(log_addr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_addr.size()) begin
        chk({tag, "_addr"}, 32'(log_addr[i]), 32'(base + 25'(i)));
        chk({tag, "_data"}, 32'(log_data[i]), 32'(first + 16'(i)));
      end
    end
  endtask

  task automatic enter(input logic [1:0] slot);
    mainState = 5'd0;
    tick();
    log_addr.delete();
    log_data.delete();
    slot_select = slot;
    mainState = 5'd4;
    tick();
  endtask

  initial begin
    logic saw_valid;
    int   n;
    reset_n = 1'b0;
    mainState = 5'd0;
    sample_strobe = 1'b0;
    sample_in = 8'h00;
    slot_select = 2'd0;
    stop_request = 1'b0;
    sdram_recievedCommand = 1'b0;
    sdram_isBusy = 1'b0;
    #3;
    chk("rst_valid", 32'(sdram_inputValid), 0);
    chk("rst_writing", 32'(sdram_isWriting), 0);
    chk("rst_addr", 32'(sdram_inputAddress), 0);
    chk("rst_data", 32'(sdram_writeData), 0);
    chk("rst_complete", 32'(stateComplete), 0);
    chk("rst_debug", debugString, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Nominal recording into slot 2.
    ack_delay = 1;
    enter(2'd2);
    wait_state(3'd2, 5, "nom_record");
    for (int i = 0; i < 8; i++) strobe(8'h10 + 8'(i), 3);
    wait_state(3'd4, 50, "nom_done");
    check_writes("nom", 8, 25'h200, 16'h0010);
    chk("nom_written", 32'(samples_written), 8);
    chk("nom_complete", 32'(stateComplete), 1);
    chk("nom_overrun", 32'(overrun), 0);
    chk("nom_debug", debugString, 32'h8000_0008);
    mainState = 5'd0;
    tick();
    chk("nom_leave_complete", 32'(stateComplete), 0);
    chk("nom_leave_written", 32'(samples_written), 8);

    // Backpressure: acknowledge withheld, FIFO fills and later samples drop.
    ack_delay = 100;
    enter(2'd1);
    wait_state(3'd2, 5, "bp_record");
    for (int i = 0; i < 8; i++) begin
      strobe(8'h20 + 8'(i), 10);
      if (i == 3) chk("bp_no_overrun_yet", 32'(overrun), 0);
      if (i == 4) chk("bp_overrun_set", 32'(overrun), 1);
    end
    chk("bp_held", 32'(log_addr.size()), 0);
    chk("bp_valid_held", 32'(sdram_inputValid), 1);
    chk("bp_addr_held", 32'(sdram_inputAddress), 32'h100);
    stop_pulse();
    wait_state(3'd4, 600, "bp_done");
    check_writes("bp", 4, 25'h100, 16'h0020);
    chk("bp_written", 32'(samples_written), 4);
    chk("bp_overrun", 32'(overrun), 1);

    // Early stop after the third strobe.
    ack_delay = 1;
    enter(2'd3);
    wait_state(3'd2, 5, "stop_record");
    for (int i = 0; i < 3; i++) strobe(8'h30 + 8'(i), 3);
    stop_pulse();
    for (int i = 0; i < 3; i++) strobe(8'h3A, 2);
    wait_state(3'd4, 50, "stop_done");
    check_writes("stop", 3, 25'h300, 16'h0030);
    chk("stop_written", 32'(samples_written), 3);
    chk("stop_complete", 32'(stateComplete), 1);

    // Abort in RECORD with a command outstanding and an overrun recorded.
    ack_delay = 1000;
    enter(2'd2);
    wait_state(3'd2, 5, "abort_record");
    for (int i = 0; i < 5; i++) strobe(8'h40 + 8'(i), 2);
    chk("abort_pre_valid", 32'(sdram_inputValid), 1);
    chk("abort_pre_overrun", 32'(overrun), 1);
    mainState = 5'd0;
    tick();
    chk("abort_valid", 32'(sdram_inputValid), 0);
    chk("abort_state", 32'(debugString[31:29]), 0);
    chk("abort_keep_overrun", 32'(overrun), 1);
    ack_delay = 1;
    enter(2'd2);
    wait_state(3'd2, 5, "reenter_record");
    chk("reenter_overrun", 32'(overrun), 0);
    chk("reenter_written", 32'(samples_written), 0);
    strobe(8'h50, 2);
    stop_pulse();
    wait_state(3'd4, 50, "reenter_done");
    check_writes("reenter", 1, 25'h200, 16'h0050);

    // Controller busy holds off the first command.
    enter(2'd0);
    wait_state(3'd2, 5, "busy_record");
    sdram_isBusy = 1'b1;
    strobe(8'h60, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_valid = saw_valid | sdram_inputValid;
    end
    chk("busy_no_valid", 32'(saw_valid), 0);
    sdram_isBusy = 1'b0;
    tick();
    chk("busy_release_valid", 32'(sdram_inputValid), 1);
    stop_pulse();
    wait_state(3'd4, 50, "busy_done");
    check_writes("busy", 1, 25'h000, 16'h0060);

    // Asynchronous reset in the middle of a command.
    ack_delay = 1000;
    enter(2'd1);
    wait_state(3'd2, 5, "areset_record");
    strobe(8'h71, 1);
    n = 0;
    while (!sdram_inputValid && n < 5) begin
      tick();
      n++;
    end
    chk("areset_pre_valid", 32'(sdram_inputValid), 1);
    chk("areset_pre_addr", 32'(sdram_inputAddress), 32'h100);
    chk("areset_pre_data", 32'(sdram_writeData), 32'h71);
    #2;
    reset_n = 1'b0;
    #2;
    chk("areset_valid", 32'(sdram_inputValid), 0);
    chk("areset_writing", 32'(sdram_isWriting), 0);
    chk("areset_addr", 32'(sdram_inputAddress), 0);
    chk("areset_data", 32'(sdram_writeData), 0);
    chk("areset_complete", 32'(stateComplete), 0);
    chk("areset_written", 32'(samples_written), 0);
    chk("areset_overrun", 32'(overrun), 0);
    chk("areset_debug", debugString, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
